// File: rtl/flash_wave_loader.sv
// Flash-to-waveform-RAM loader: reads bytes from flash_ctrl, packs them MSB-first into
// samples, and writes each sample to the waveform RAM. Timeout on every flash wait.
module flash_wave_loader #(
  parameter int ADDR_NBIT     = 24,
  parameter int DATA_NBIT     = 8,
  parameter int SAMPLE_NBYTE  = 2,
  parameter int RAM_ADDR_NBIT = 12,
  parameter int TO_NBIT       = 12
) (
  input  logic                              mclk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [ADDR_NBIT-1:0]              base_addr,
  input  logic [RAM_ADDR_NBIT-1:0]          num_samples,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              flash_rd,
  output logic [ADDR_NBIT-1:0]              flash_raddr,
  input  logic                              flash_rstatus,
  input  logic [DATA_NBIT-1:0]              flash_rdata,
  input  logic                              flash_rdv,
  output logic                              wr_en,
  output logic [RAM_ADDR_NBIT-1:0]          wr_addr,
  output logic [SAMPLE_NBYTE*DATA_NBIT-1:0] wr_data
);
  localparam int SW = SAMPLE_NBYTE * DATA_NBIT;
  localparam logic [TO_NBIT-1:0] TO_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_BUSY, S_WAIT_DATA, S_WRITE, S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [RAM_ADDR_NBIT-1:0] n_lat;
  logic [SW-1:0]            sample, sample_nxt;
  logic [1:0]               byte_cnt;
  logic [TO_NBIT-1:0]       to_cnt;
  logic                     to_hit, byte_last, smp_last, accept, wait_st;

  assign to_hit     = (to_cnt == TO_MAX);
  assign byte_last  = (byte_cnt == 2'(SAMPLE_NBYTE - 1));
  assign smp_last   = (wr_addr == n_lat - RAM_ADDR_NBIT'(1));
  assign wait_st    = (state == S_REQ) || (state == S_WAIT_BUSY) || (state == S_WAIT_DATA);
  assign sample_nxt = (sample << DATA_NBIT) | SW'(flash_rdata);

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign wr_en = (state == S_WRITE);

  always_comb begin
    state_nxt = state;
    flash_rd  = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE:      if (start) state_nxt = (num_samples == '0) ? S_DONE : S_REQ;
      S_REQ: begin
        if (to_hit) state_nxt = S_DONE;
        else if (flash_rstatus) begin
          flash_rd  = 1'b1;
          state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (to_hit) state_nxt = S_DONE;
        else if (!flash_rstatus) state_nxt = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        // timeout wins over a byte arriving in the same cycle
        if (to_hit) state_nxt = S_DONE;
        else if (flash_rstatus && flash_rdv) begin
          accept    = 1'b1;
          state_nxt = byte_last ? S_WRITE : S_REQ;
        end
      end
      S_WRITE:     state_nxt = smp_last ? S_DONE : S_REQ;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      err         <= 1'b0;
      flash_raddr <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      n_lat       <= '0;
      sample      <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) to_cnt <= '0;
      else if (wait_st)       to_cnt <= to_cnt + TO_NBIT'(1);
      if (wait_st && to_hit) err <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          n_lat       <= num_samples;
          flash_raddr <= base_addr;
          err         <= 1'b0;
          wr_addr     <= '0;
          byte_cnt    <= '0;
          sample      <= '0;
        end
        S_WAIT_DATA: if (accept) begin
          flash_raddr <= flash_raddr + ADDR_NBIT'(1);
          if (byte_last) begin
            byte_cnt <= '0;
            wr_data  <= sample_nxt;
            sample   <= '0;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
            sample   <= sample_nxt;
          end
        end
        // hold on the last sample so wr_addr stays within 0..num_samples-1
        S_WRITE: if (!smp_last) wr_addr <= wr_addr + RAM_ADDR_NBIT'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_wave_loader.sv
// Bench for flash_wave_loader: flash_ctrl behavioural stand-in, queue-based expected
// read/write sequences built from base/count, checked on every output strobe.
module tb_flash_wave_loader;
  localparam int AW = 24, DW = 8, NB = 2, RW = 12, TW = 12;
  localparam int SW = NB * DW;

  logic          mclk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [RW-1:0] num_samples = '0;
  logic          busy, done, err, flash_rd, wr_en;
  logic [AW-1:0] flash_raddr;
  logic [RW-1:0] wr_addr;
  logic [SW-1:0] wr_data;
  logic          flash_rstatus = 1'b0, flash_rdv = 1'b0;
  logic [DW-1:0] flash_rdata = '0;

  flash_wave_loader #(.ADDR_NBIT(AW), .DATA_NBIT(DW), .SAMPLE_NBYTE(NB),
                      .RAM_ADDR_NBIT(RW), .TO_NBIT(TW)) dut (
    .mclk(mclk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_samples(num_samples), .busy(busy), .done(done), .err(err),
    .flash_rd(flash_rd), .flash_raddr(flash_raddr), .flash_rstatus(flash_rstatus),
    .flash_rdata(flash_rdata), .flash_rdv(flash_rdv), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data));

  always #5 mclk = ~mclk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // flash_ctrl stand-in: not reset, busy for fl_cnt cycles at power-up and per read
  logic [DW-1:0] key = 8'h00;
  int            fl_mode = 0, fl_lat = 4, fl_cnt = 10;
  logic [AW-1:0] fl_addr = '0;
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[7:0] ^ key;
  endfunction
  always @(posedge mclk) begin
    if (fl_cnt > 0) begin
      fl_cnt <= fl_cnt - 1;
      if (fl_cnt == 1) begin
        flash_rstatus <= 1'b1;
        flash_rdv     <= 1'b1;
        flash_rdata   <= mem(fl_addr);
      end
    end else if (flash_rd && fl_mode == 0) begin
      flash_rstatus <= 1'b0;
      flash_rdv     <= 1'b0;
      fl_addr       <= flash_raddr;
      fl_cnt        <= fl_lat;
    end
  end

  // expected traffic and observed logs
  logic [AW-1:0] exp_rd[$], log_ra[$];
  logic [RW-1:0] exp_wa[$], log_wa[$];
  logic [SW-1:0] exp_wd[$], log_wd[$];
  logic          exp_err = 1'b0;
  int            done_cnt = 0, last_done_cyc = 0, last_rd_cyc = 0;

  task automatic plan_load(input logic [AW-1:0] base, input int num);
    for (int s = 0; s < num; s++) begin
      logic [SW-1:0] d = '0;
      for (int b = 0; b < NB; b++) begin
        logic [AW-1:0] a = base + AW'(s * NB + b);
        exp_rd.push_back(a);
        d = (d << DW) | SW'(mem(a));
      end
      exp_wa.push_back(RW'(s));
      exp_wd.push_back(d);
    end
  endtask

  task automatic clr();
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    log_ra.delete(); log_wa.delete(); log_wd.delete();
  endtask

  always @(negedge mclk) if (rst_n) begin
    if (flash_rd) begin
      check("rd_while_flash_busy", flash_rstatus, 1);
      check("rd_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) check("rd_addr", flash_raddr, exp_rd.pop_front());
      log_ra.push_back(flash_raddr);
      last_rd_cyc = cyc;
    end
    if (wr_en) begin
      check("wr_expected", exp_wa.size() != 0, 1);
      if (exp_wa.size() != 0) begin
        check("wr_addr", wr_addr, exp_wa.pop_front());
        check("wr_data", wr_data, exp_wd.pop_front());
      end
      log_wa.push_back(wr_addr);
      log_wd.push_back(wr_data);
    end
    if (done) begin
      check("done_err", err, exp_err);
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  int d0, t0;

  task automatic do_start(input logic [AW-1:0] base, input logic [RW-1:0] num);
    @(negedge mclk);
    base_addr = base; num_samples = num; start = 1'b1; t0 = cyc; d0 = done_cnt;
    @(negedge mclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (n < budget) begin
      @(posedge mclk); #1;
      if (done) break;
      n++;
    end
    check({nm, "_done_seen"}, done, 1);
  endtask

  task automatic end_check(input string nm);
    repeat (2) @(negedge mclk);
    check({nm, "_rd_left"}, exp_rd.size(), 0);
    check({nm, "_wr_left"}, exp_wa.size(), 0);
    check({nm, "_done_cnt"}, done_cnt - d0, 1);
    check({nm, "_busy_idle"}, busy, 0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ctl"}, {busy, done, err, flash_rd, wr_en}, 0);
    check({nm, "_raddr"}, flash_raddr, 0);
    check({nm, "_waddr"}, wr_addr, 0);
    check({nm, "_wdata"}, wr_data, 0);
  endtask

  initial begin
    repeat (3) @(negedge mclk);
    check_zero("reset");
    rst_n = 1'b1;

    // 1: basic load, also exercises power-up wait on rstatus
    clr(); plan_load(24'h000100, 3); exp_err = 1'b0;
    do_start(24'h000100, 3);
    wait_done(300, "t1");
    end_check("t1");
    check("t1_nrd", log_ra.size(), 6);
    if (log_ra.size() == 6) begin
      check("t1_ra0", log_ra[0], 24'h000100);
      check("t1_ra5", log_ra[5], 24'h000105);
    end
    check("t1_nwr", log_wd.size(), 3);
    if (log_wd.size() == 3) begin
      check("t1_wd0", log_wd[0], 16'h0001);
      check("t1_wd1", log_wd[1], 16'h0203);
      check("t1_wd2", log_wd[2], 16'h0405);
      check("t1_wa2", log_wa[2], 2);
    end
    check("t1_err", err, 0);

    // 2: zero-length load
    clr();
    do_start(24'h000500, 0);
    end_check("t2");
    check("t2_latency_ok", (last_done_cyc - t0) inside {[1:2]}, 1);
    check("t2_no_rd", log_ra.size(), 0);
    check("t2_no_wr", log_wd.size(), 0);

    // 3: address wrap
    clr(); plan_load(24'hFFFFFF, 1);
    do_start(24'hFFFFFF, 1);
    wait_done(300, "t3");
    end_check("t3");
    if (log_ra.size() == 2) begin
      check("t3_ra0", log_ra[0], 24'hFFFFFF);
      check("t3_ra1", log_ra[1], 24'h000000);
    end else check("t3_nrd", log_ra.size(), 2);
    if (log_wd.size() == 1) check("t3_wd", log_wd[0], 16'hFF00);
    else check("t3_nwr", log_wd.size(), 1);

    // 4: flash never accepts -> timeout, then recovery
    clr(); fl_mode = 1; exp_rd.push_back(24'h000200); exp_err = 1'b1;
    do_start(24'h000200, 2);
    wait_done(5000, "t4");
    end_check("t4");
    check("t4_timeout_window", (last_done_cyc - last_rd_cyc) inside {[4090:4100]}, 1);
    check("t4_no_wr", log_wd.size(), 0);
    repeat (3) @(negedge mclk);
    check("t4_err_sticky", err, 1);
    fl_mode = 0;
    clr(); plan_load(24'h000300, 2); exp_err = 1'b0;
    do_start(24'h000300, 2);
    check("t4_err_cleared", err, 0);
    wait_done(300, "t4b");
    end_check("t4b");

    // 5: start held high, inputs scrambled during load
    clr(); key = 8'h5A; plan_load(24'h001234, 4);
    @(negedge mclk);
    base_addr = 24'h001234; num_samples = 4; start = 1'b1; d0 = done_cnt;
    for (int n = 0; n < 500; n++) begin
      @(negedge mclk);
      base_addr = AW'($urandom); num_samples = RW'($urandom);
      if (done) break;
    end
    start = 1'b0;
    end_check("t5");
    check("t5_nwr", log_wd.size(), 4);

    // 6: reset during second sample's data wait
    clr(); key = 8'hC3; plan_load(24'h000040, 3);
    do_start(24'h000040, 3);
    for (int n = 0; n < 300 && log_ra.size() < 2; n++) @(negedge mclk);
    fl_lat = 30;
    for (int n = 0; n < 300 && log_ra.size() < 3; n++) @(negedge mclk);
    check("t6_reached_3rd_rd", log_ra.size(), 3);
    repeat (3) @(negedge mclk);
    #2 rst_n = 1'b0;
    #1 check_zero("t6_async");
    clr();
    repeat (2) @(negedge mclk);
    rst_n = 1'b1; fl_lat = 4;
    plan_load(24'h000040, 3); exp_err = 1'b0;
    do_start(24'h000040, 3);
    wait_done(300, "t6");
    end_check("t6");
    if (log_wd.size() == 3) begin
      check("t6_wa0", log_wa[0], 0);
      check("t6_wd0", log_wd[0], 16'h8382);
    end else check("t6_nwr", log_wd.size(), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
